// File: rtl/bcd_event_counter_pkg.sv
// Shared definitions for the BCD event counter.
//   BCD_W    : bits per BCD digit
//   BCD_MAX  : largest legal digit value
//   packed_w : width of a packed all-channel count vector
package bcd_event_counter_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic int packed_w(input int num_ch, input int num_digits);
    return num_ch * num_digits * BCD_W;
  endfunction

endpackage

// File: rtl/bcd_counter_chain.sv
// One channel's BCD counter: NUM_DIGITS cascaded decimal digits.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   inc          : single-cycle increment request
//   clear        : synchronous clear, wins over inc
//   digits       : packed BCD value, digit 0 in the LSBs
//   wrap         : combinational, high when inc arrives at all-nines
// SAT_MODE = 0 wraps to zero at end of range, 1 holds at all-nines.
module bcd_counter_chain
  import bcd_event_counter_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SAT_MODE   = 0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        inc,
  input  logic                        clear,
  output logic [NUM_DIGITS*BCD_W-1:0] digits,
  output logic                        wrap
);

  logic [NUM_DIGITS*BCD_W-1:0] digits_next;
  logic                        carry;

  // Ripple the carry through every digit in one cycle. A digit at or
  // above nine rolls to zero, so an out-of-range digit can never persist.
  always_comb begin
    digits_next = digits;
    carry       = inc;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (carry) begin
        if (digits[d*BCD_W +: BCD_W] >= BCD_MAX) begin
          digits_next[d*BCD_W +: BCD_W] = '0;
        end else begin
          digits_next[d*BCD_W +: BCD_W] = digits[d*BCD_W +: BCD_W] + 4'd1;
          carry                         = 1'b0;
        end
      end
    end
    wrap = carry;
    if (SAT_MODE != 0 && carry) begin
      digits_next = digits;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digits <= '0;
    end else if (clear) begin
      digits <= '0;
    end else begin
      digits <= digits_next;
    end
  end

endmodule

// File: rtl/bcd_event_counter.sv
// Multi-channel BCD event counter with snapshot.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   event_in     : raw asynchronous event levels, one per channel
//   enable       : per-channel count enable
//   clear        : per-channel synchronous clear of count and overflow
//   latch        : copies all live counts into snapshot on the next edge
//   count        : live BCD counts, channel 0 in the LSBs
//   snapshot     : latched BCD counts, same packing as count
//   snap_valid   : one-cycle pulse when snapshot updates
//   overflow     : sticky per-channel end-of-range flag
// A rising event edge changes count three clocks after it is sampled:
// two synchroniser flops, then the edge register/counter update.
module bcd_event_counter
  import bcd_event_counter_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int NUM_DIGITS = 4,
  parameter int SAT_MODE   = 0
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NUM_CH-1:0]                     event_in,
  input  logic [NUM_CH-1:0]                     enable,
  input  logic [NUM_CH-1:0]                     clear,
  input  logic                                  latch,
  output logic [packed_w(NUM_CH,NUM_DIGITS)-1:0] count,
  output logic [packed_w(NUM_CH,NUM_DIGITS)-1:0] snapshot,
  output logic                                  snap_valid,
  output logic [NUM_CH-1:0]                     overflow
);

  localparam int CW = NUM_DIGITS * BCD_W;

  logic [NUM_CH-1:0] sync_1;
  logic [NUM_CH-1:0] sync_2;
  logic [NUM_CH-1:0] edge_q;
  logic [NUM_CH-1:0] inc;
  logic [NUM_CH-1:0] count_inc;
  logic [NUM_CH-1:0] wrap;
  logic [2:0]        prime_q;

  // The synchroniser and edge register always run, independent of
  // enable, so re-enabling a channel never sees a stale edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
      edge_q <= '0;
    end else begin
      sync_1 <= event_in;
      sync_2 <= sync_1;
      edge_q <= sync_2;
    end
  end

  // Edge detection is held off until the pipeline has been refilled
  // after reset, so a level already high at release is not an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prime_q <= '0;
    end else begin
      prime_q <= {prime_q[1:0], 1'b1};
    end
  end

  assign inc       = sync_2 & ~edge_q & {NUM_CH{prime_q[2]}};
  assign count_inc = inc & enable;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    bcd_counter_chain #(
      .NUM_DIGITS (NUM_DIGITS),
      .SAT_MODE   (SAT_MODE)
    ) u_chain (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (count_inc[g]),
      .clear   (clear[g]),
      .digits  (count[g*CW +: CW]),
      .wrap    (wrap[g])
    );
  end

  // Clear wins over a same-cycle end-of-range increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= '0;
    end else begin
      overflow <= (overflow | wrap) & ~clear;
    end
  end

  // Snapshot samples the registered count, so it always captures the
  // value from before any same-cycle increment or clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snapshot   <= '0;
      snap_valid <= 1'b0;
    end else begin
      if (latch) begin
        snapshot <= count;
      end
      snap_valid <= latch;
    end
  end

endmodule
